hdmi_pattern_sequencer: RTL and testbench

Video test-pattern controller in the clk_pixel domain. It drives the rgb input of the hdmi encoder from the cx/cy counters that the encoder returns. It detects frame boundaries and selects one of four patterns. The pattern advances automatically every FRAMES_PER_PATTERN frames, on a step request, or by a forced select. Pattern changes take effect only at a frame boundary, so no frame ever shows torn content.

---
 rtl/hdmi_pattern_pkg.sv | 37 +++
 rtl/hdmi_pattern_gen.sv | 75 +++++++
 rtl/hdmi_pattern_sequencer.sv | 170 +++++++++++++++++
 tb/tb_hdmi_pattern_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pattern_pkg.sv
// Shared types and constants for the HDMI test-pattern sequencer.
//   pattern_e   : pattern selector (bars, stripes, border, moving bar)
//   seq_state_e : sequencer FSM states
//   COL_*       : 24-bit {R,G,B} colour constants
package hdmi_pattern_pkg;

  localparam int unsigned CX_W    = 11;
  localparam int unsigned CY_W    = 10;
  localparam int unsigned RGB_W   = 24;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned PAT_W   = 2;
  localparam int unsigned BAR_LEN = 32;

  typedef enum logic [PAT_W-1:0] {
    PAT_BARS    = 2'd0,
    PAT_STRIPES = 2'd1,
    PAT_BORDER  = 2'd2,
    PAT_MOVBAR  = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    AUTO     = 2'd1,
    HOLD     = 2'd2
  } seq_state_e;

  localparam logic [RGB_W-1:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [RGB_W-1:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [RGB_W-1:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [RGB_W-1:0] COL_GREEN   = 24'h00FF00;
  localparam logic [RGB_W-1:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [RGB_W-1:0] COL_RED     = 24'hFF0000;
  localparam logic [RGB_W-1:0] COL_BLUE    = 24'h0000FF;
  localparam logic [RGB_W-1:0] COL_BLACK   = 24'h000000;
  localparam logic [RGB_W-1:0] COL_GREY    = 24'h404040;

endpackage

// File: rtl/hdmi_pattern_gen.sv
// Combinational pattern lookup.
//   pattern    : pattern to render
//   cx, cy     : pixel coordinate (assumed inside the active area)
//   bar_x      : left edge of the moving bar
//   rgb_next_c : {R,G,B} for that pixel, unregistered
module hdmi_pattern_gen
  import hdmi_pattern_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH  = 1280,
  parameter int unsigned SCREEN_HEIGHT = 720
) (
  input  pattern_e           pattern,
  input  logic [CX_W-1:0]    cx,
  input  logic [CY_W-1:0]    cy,
  input  logic [CX_W-1:0]    bar_x,
  output logic [RGB_W-1:0]   rgb_next_c
);

  // Bar edges as constant multiples of the bar width.
  localparam logic [CX_W-1:0] BAR1 = CX_W'(1 * SCREEN_WIDTH / 8);
  localparam logic [CX_W-1:0] BAR2 = CX_W'(2 * SCREEN_WIDTH / 8);
  localparam logic [CX_W-1:0] BAR3 = CX_W'(3 * SCREEN_WIDTH / 8);
  localparam logic [CX_W-1:0] BAR4 = CX_W'(4 * SCREEN_WIDTH / 8);
  localparam logic [CX_W-1:0] BAR5 = CX_W'(5 * SCREEN_WIDTH / 8);
  localparam logic [CX_W-1:0] BAR6 = CX_W'(6 * SCREEN_WIDTH / 8);
  localparam logic [CX_W-1:0] BAR7 = CX_W'(7 * SCREEN_WIDTH / 8);

  localparam logic [CY_W-1:0] STRIPE1 = CY_W'(SCREEN_HEIGHT / 3);
  localparam logic [CY_W-1:0] STRIPE2 = CY_W'(2 * SCREEN_HEIGHT / 3);

  localparam logic [CX_W-1:0] X_LAST = CX_W'(SCREEN_WIDTH - 1);
  localparam logic [CY_W-1:0] Y_LAST = CY_W'(SCREEN_HEIGHT - 1);

  // Moving-bar window compared one bit wider so bar_x+32 never overflows.
  logic [CX_W:0] cx_w;
  logic [CX_W:0] bar_lo;
  logic [CX_W:0] bar_hi;

  assign cx_w   = (CX_W+1)'(cx);
  assign bar_lo = (CX_W+1)'(bar_x);
  assign bar_hi = (CX_W+1)'(bar_x) + (CX_W+1)'(BAR_LEN);

  // Pattern lookup.
  always_comb begin
    rgb_next_c = COL_BLACK;
    case (pattern)
      PAT_BARS: begin
        if      (cx < BAR1) rgb_next_c = COL_WHITE;
        else if (cx < BAR2) rgb_next_c = COL_YELLOW;
        else if (cx < BAR3) rgb_next_c = COL_CYAN;
        else if (cx < BAR4) rgb_next_c = COL_GREEN;
        else if (cx < BAR5) rgb_next_c = COL_MAGENTA;
        else if (cx < BAR6) rgb_next_c = COL_RED;
        else if (cx < BAR7) rgb_next_c = COL_BLUE;
        else                rgb_next_c = COL_BLACK;
      end
      PAT_STRIPES: begin
        if      (cy < STRIPE1) rgb_next_c = COL_RED;
        else if (cy < STRIPE2) rgb_next_c = COL_GREEN;
        else                   rgb_next_c = COL_BLUE;
      end
      PAT_BORDER: begin
        if      (cx == '0)                      rgb_next_c = COL_RED;
        else if (cy == '0)                      rgb_next_c = COL_GREEN;
        else if ((cx == X_LAST) || (cy == Y_LAST)) rgb_next_c = COL_BLUE;
        else                                    rgb_next_c = COL_BLACK;
      end
      default: begin
        if ((cx_w >= bar_lo) && (cx_w < bar_hi)) rgb_next_c = COL_WHITE;
        else                                     rgb_next_c = COL_GREY;
      end
    endcase
  end

endmodule

// File: rtl/hdmi_pattern_sequencer.sv
// Test-pattern sequencer: detects frame starts from the encoder's cx/cy,
// selects and advances the pattern at frame boundaries only, and registers
// the rendered pixel one clock after the coordinate it belongs to.
//   clk_pixel, sys_resetn : pixel clock, async active-low reset
//   cx, cy                : encoder pixel/line counters
//   auto_en               : auto-advance enable (sampled at frame start)
//   step_req, sel_valid   : one-cycle requests, applied at next frame start
//   sel_idx               : pattern forced by sel_valid
//   rgb                   : registered pixel to the encoder
//   pattern_idx           : pattern currently displayed
//   frame_start           : registered pulse for a sampled (0,0)
//   frame_cnt             : frames shown of the current pattern
module hdmi_pattern_sequencer
  import hdmi_pattern_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH        = 1650,
  parameter int unsigned FRAME_HEIGHT       = 750,
  parameter int unsigned SCREEN_WIDTH       = 1280,
  parameter int unsigned SCREEN_HEIGHT      = 720,
  parameter int unsigned FRAMES_PER_PATTERN = 120,
  parameter int unsigned BAR_STEP           = 4
) (
  input  logic              clk_pixel,
  input  logic              sys_resetn,
  input  logic [CX_W-1:0]   cx,
  input  logic [CY_W-1:0]   cy,
  input  logic              auto_en,
  input  logic              step_req,
  input  logic              sel_valid,
  input  logic [PAT_W-1:0]  sel_idx,
  output logic [RGB_W-1:0]  rgb,
  output logic [PAT_W-1:0]  pattern_idx,
  output logic              frame_start,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam logic [CX_W-1:0]  SCR_W    = CX_W'(SCREEN_WIDTH);
  localparam logic [CY_W-1:0]  SCR_H    = CY_W'(SCREEN_HEIGHT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_PATTERN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CX_W:0]    STEP_W   = (CX_W+1)'(BAR_STEP);
  localparam logic [CX_W:0]    SCR_W_W  = (CX_W+1)'(SCREEN_WIDTH);

  // Frame geometry is owned by the encoder; kept for interface completeness.
  localparam int unsigned FRAME_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;
  if (FRAME_PIXELS == 0) begin : g_bad_frame
    $error("frame size must be non-zero");
  end

  seq_state_e              state_q,       state_d;
  pattern_e                pattern_q,     pattern_d;
  logic [CNT_W-1:0]        frame_cnt_q,   frame_cnt_d;
  logic [CX_W-1:0]         bar_x_q,       bar_x_d;
  logic [RGB_W-1:0]        rgb_q,         rgb_d;
  logic                    frame_start_q, frame_start_d;
  logic                    sel_pend_q,    sel_pend_d;
  logic [PAT_W-1:0]        sel_idx_q,     sel_idx_d;
  logic                    step_pend_q,   step_pend_d;

  logic                    sof_c;
  logic [CX_W:0]           bar_sum_c;
  logic [RGB_W-1:0]        gen_rgb_c;
  logic                    active_c;

  assign sof_c     = (cx == '0) && (cy == '0);
  assign active_c  = (cx < SCR_W) && (cy < SCR_H);
  assign bar_sum_c = (CX_W+1)'(bar_x_q) + STEP_W;

  // State register.
  always_ff @(posedge clk_pixel or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_q       <= WAIT_SOF;
      pattern_q     <= PAT_BARS;
      frame_cnt_q   <= '0;
      bar_x_q       <= '0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
      sel_pend_q    <= 1'b0;
      sel_idx_q     <= '0;
      step_pend_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pattern_q     <= pattern_d;
      frame_cnt_q   <= frame_cnt_d;
      bar_x_q       <= bar_x_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
      sel_pend_q    <= sel_pend_d;
      sel_idx_q     <= sel_idx_d;
      step_pend_q   <= step_pend_d;
    end
  end

  // Next-state: requests latch mid-frame; everything changes only at (0,0).
  always_comb begin
    state_d       = state_q;
    pattern_d     = pattern_q;
    frame_cnt_d   = frame_cnt_q;
    bar_x_d       = bar_x_q;
    frame_start_d = sof_c;
    sel_pend_d    = sel_pend_q;
    sel_idx_d     = sel_idx_q;
    step_pend_d   = step_pend_q;

    if (sof_c) begin
      // Requests seen on the boundary cycle itself wait for the next one.
      sel_pend_d  = sel_valid;
      step_pend_d = step_req;
      if (sel_valid) sel_idx_d = sel_idx;

      if (bar_sum_c >= SCR_W_W) bar_x_d = CX_W'(bar_sum_c - SCR_W_W);
      else                      bar_x_d = CX_W'(bar_sum_c);

      if (sel_pend_q) begin
        pattern_d   = pattern_e'(sel_idx_q);
        frame_cnt_d = '0;
      end else if (step_pend_q) begin
        pattern_d   = pattern_e'(PAT_W'(pattern_q) + PAT_W'(1));
        frame_cnt_d = '0;
      end else begin
        case (state_q)
          AUTO: begin
            if (frame_cnt_q == CNT_LAST) begin
              pattern_d   = pattern_e'(PAT_W'(pattern_q) + PAT_W'(1));
              frame_cnt_d = '0;
            end else begin
              frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
          end
          HOLD: begin
            if (frame_cnt_q != CNT_MAX) frame_cnt_d = frame_cnt_q + CNT_W'(1);
          end
          default: ;
        endcase
      end

      state_d = auto_en ? AUTO : HOLD;
    end else begin
      if (sel_valid) begin
        sel_pend_d = 1'b1;
        sel_idx_d  = sel_idx;
      end
      if (step_req) step_pend_d = 1'b1;
    end
  end

  // Render with the next pattern/bar so the boundary pixel uses the new frame's settings.
  hdmi_pattern_gen #(
    .SCREEN_WIDTH  (SCREEN_WIDTH),
    .SCREEN_HEIGHT (SCREEN_HEIGHT)
  ) u_gen (
    .pattern    (pattern_d),
    .cx         (cx),
    .cy         (cy),
    .bar_x      (bar_x_d),
    .rgb_next_c (gen_rgb_c)
  );

  // Blank outside the active area and until the first frame start.
  always_comb begin
    rgb_d = '0;
    if ((state_d != WAIT_SOF) && active_c) rgb_d = gen_rgb_c;
  end

  assign rgb         = rgb_q;
  assign pattern_idx = PAT_W'(pattern_q);
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_hdmi_pattern_sequencer.sv
module tb_hdmi_pattern_sequencer;

  logic        clk_pixel = 1'b0;
  logic        sys_resetn;
  logic [10:0] cx;
  logic [9:0]  cy;
  logic        auto_en;
  logic        step_req;
  logic        sel_valid;
  logic [1:0]  sel_idx;
  logic [23:0] rgb;
  logic [1:0]  pattern_idx;
  logic        frame_start;
  logic [7:0]  frame_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int nsof   = 0;

  hdmi_pattern_sequencer #(
    .FRAME_WIDTH        (1650),
    .FRAME_HEIGHT       (750),
    .SCREEN_WIDTH       (1280),
    .SCREEN_HEIGHT      (720),
    .FRAMES_PER_PATTERN (2),
    .BAR_STEP           (4)
  ) dut (
    .clk_pixel   (clk_pixel),
    .sys_resetn  (sys_resetn),
    .cx          (cx),
    .cy          (cy),
    .auto_en     (auto_en),
    .step_req    (step_req),
    .sel_valid   (sel_valid),
    .sel_idx     (sel_idx),
    .rgb         (rgb),
    .pattern_idx (pattern_idx),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present (x,y) for one rising edge; outputs for that pixel are valid on return.
  task automatic drive(input int x, input int y);
    @(negedge clk_pixel);
    cx = 11'(x);
    cy = 10'(y);
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic sof();
    drive(0, 0);
    nsof++;
  endtask

  task automatic drive_step(input int x, input int y);
    step_req = 1'b1;
    drive(x, y);
    step_req = 1'b0;
  endtask

  task automatic drive_sel(input int x, input int y, input logic [1:0] idx);
    sel_valid = 1'b1;
    sel_idx   = idx;
    drive(x, y);
    sel_valid = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_pat [8];
    logic [7:0] exp_cnt [8];
    exp_pat[0] = 2'd0; exp_cnt[0] = 8'd1;
    exp_pat[1] = 2'd1; exp_cnt[1] = 8'd0;
    exp_pat[2] = 2'd1; exp_cnt[2] = 8'd1;
    exp_pat[3] = 2'd2; exp_cnt[3] = 8'd0;
    exp_pat[4] = 2'd2; exp_cnt[4] = 8'd1;
    exp_pat[5] = 2'd3; exp_cnt[5] = 8'd0;
    exp_pat[6] = 2'd3; exp_cnt[6] = 8'd1;
    exp_pat[7] = 2'd0; exp_cnt[7] = 8'd0;

    // Reset held mid-frame.
    sys_resetn = 1'b0;
    cx = 11'd500; cy = 10'd300;
    auto_en = 1'b1; step_req = 1'b0; sel_valid = 1'b0; sel_idx = 2'd0;
    repeat (3) @(posedge clk_pixel);
    #1;
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_pat", 32'(pattern_idx), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk_pixel);
    sys_resetn = 1'b1;

    // No video before the first (0,0).
    drive(500, 300);
    chk("wait_rgb0", 32'(rgb), 32'h0);
    drive(100, 100);
    chk("wait_rgb1", 32'(rgb), 32'h0);
    chk("wait_fs", 32'(frame_start), 32'd0);

    // First frame: colour bars.
    sof();
    chk("sof1_fs", 32'(frame_start), 32'd1);
    chk("sof1_pat", 32'(pattern_idx), 32'd0);
    chk("sof1_rgb", 32'(rgb), 32'hFFFFFF);
    drive(159, 0);
    chk("bar_159", 32'(rgb), 32'hFFFFFF);
    chk("fs_low", 32'(frame_start), 32'd0);
    drive(160, 0);
    chk("bar_160", 32'(rgb), 32'hFFFF00);
    drive(1119, 10);
    chk("bar_1119", 32'(rgb), 32'h0000FF);
    drive(1120, 10);
    chk("bar_1120", 32'(rgb), 32'h000000);

    // Auto advance with two frames per pattern.
    for (int i = 0; i < 8; i++) begin
      drive(700, 400);
      sof();
      chk($sformatf("auto_pat%0d", i), 32'(pattern_idx), 32'(exp_pat[i]));
      chk($sformatf("auto_cnt%0d", i), 32'(frame_cnt), 32'(exp_cnt[i]));
    end

    // Switch to hold; auto_en sampled at the boundary.
    auto_en = 1'b0;
    drive(700, 400);
    sof();
    chk("hold_pat", 32'(pattern_idx), 32'd0);
    chk("hold_cnt", 32'(frame_cnt), 32'd1);

    // step + two sels in one frame: last sel wins, applied once.
    drive(700, 400);
    drive_step(10, 10);
    drive_sel(15, 15, 2'd1);
    drive_sel(20, 20, 2'd2);
    chk("req_midframe_pat", 32'(pattern_idx), 32'd0);
    sof();
    chk("req_pat", 32'(pattern_idx), 32'd2);
    chk("req_cnt", 32'(frame_cnt), 32'd0);
    chk("border_00", 32'(rgb), 32'hFF0000);
    drive(700, 400);
    sof();
    chk("req_once_pat", 32'(pattern_idx), 32'd2);
    chk("req_once_cnt", 32'(frame_cnt), 32'd1);

    // Border pattern.
    drive(0, 5);
    chk("border_left", 32'(rgb), 32'hFF0000);
    drive(5, 0);
    chk("border_top", 32'(rgb), 32'h00FF00);
    drive(1279, 5);
    chk("border_right", 32'(rgb), 32'h0000FF);
    drive(5, 719);
    chk("border_bottom", 32'(rgb), 32'h0000FF);
    drive(640, 360);
    chk("border_fill", 32'(rgb), 32'h000000);

    // Stripes.
    drive_sel(30, 30, 2'd1);
    sof();
    chk("stripe_pat", 32'(pattern_idx), 32'd1);
    drive(5, 239);
    chk("stripe_239", 32'(rgb), 32'hFF0000);
    drive(5, 240);
    chk("stripe_240", 32'(rgb), 32'h00FF00);
    drive(5, 480);
    chk("stripe_480", 32'(rgb), 32'h0000FF);
    drive(1280, 100);
    chk("stripe_hblank", 32'(rgb), 32'h0);

    // Hold for 300 frames: no advance, counter saturates.
    for (int i = 0; i < 300; i++) begin
      drive(700, 400);
      sof();
    end
    chk("sat_pat", 32'(pattern_idx), 32'd1);
    chk("sat_cnt", 32'(frame_cnt), 32'd255);

    // Moving bar: run until bar_x sits at 1276, then wrap.
    drive_sel(30, 30, 2'd3);
    sof();
    chk("mov_pat", 32'(pattern_idx), 32'd3);
    while ((nsof % 320) != 319) begin
      drive(700, 400);
      sof();
    end
    drive(1276, 100);
    chk("mov_1276", 32'(rgb), 32'hFFFFFF);
    drive(1279, 100);
    chk("mov_1279", 32'(rgb), 32'hFFFFFF);
    drive(1275, 100);
    chk("mov_1275", 32'(rgb), 32'h404040);
    drive(0, 100);
    chk("mov_nowrap0", 32'(rgb), 32'h404040);
    drive(700, 400);
    sof();
    chk("mov_wrap_00", 32'(rgb), 32'hFFFFFF);
    drive(31, 100);
    chk("mov_wrap_31", 32'(rgb), 32'hFFFFFF);
    drive(32, 100);
    chk("mov_wrap_32", 32'(rgb), 32'h404040);
    drive(100, 720);
    chk("mov_vblank", 32'(rgb), 32'h0);

    // Reset mid-frame: immediate return, then wait for (0,0).
    drive(600, 300);
    chk("pre_rst_rgb", 32'(rgb), 32'h404040);
    sys_resetn = 1'b0;
    #1;
    chk("async_rgb", 32'(rgb), 32'h0);
    chk("async_pat", 32'(pattern_idx), 32'd0);
    chk("async_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk_pixel);
    sys_resetn = 1'b1;
    drive(640, 360);
    chk("rerst_wait_rgb", 32'(rgb), 32'h0);
    sof();
    chk("rerst_fs", 32'(frame_start), 32'd1);
    chk("rerst_rgb", 32'(rgb), 32'hFFFFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
